// File: rtl/flop_pipe_stage.sv
// Purpose: one register stage of the elastic pipe (valid flop + data register).
// Latency: 1 cycle from upstream beat to stage output when enabled.
// Backpressure: holds state while en is low; the ready chain lives in the parent.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   flush           - synchronous clear of the valid bit (data untouched)
//   en              - stage may load this cycle (empty or downstream advancing)
//   up_valid/up_data- beat offered by the upstream stage (or the input port)
//   valid/data      - registered stage contents
module flop_pipe_stage #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] RST_VAL  = '0,
  parameter bit               RST_DATA = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             en,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Data only toggles when a real beat is captured; flush and reset leave it
  // alone (reset handles it separately below when RST_DATA is set).
  logic load;
  assign load = en && up_valid && !flush && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (en) begin
      valid <= up_valid;
    end
  end

  generate
    if (RST_DATA) begin : g_rst_data
      always_ff @(posedge clk) begin
        if (rst) begin
          data <= RST_VAL;
        end else if (load) begin
          data <= up_data;
        end
      end
    end else begin : g_no_rst_data
      always_ff @(posedge clk) begin
        if (load) begin
          data <= up_data;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/flop_pipe_sync_rst.sv
// Purpose: DEPTH-stage elastic register pipeline with occupancy count and flush.
// Latency: DEPTH cycles from input handshake to out_valid through an empty pipe.
// Backpressure: valid/ready; bubbles collapse under stall, in_ready low only when full and stalled or flushing.
//
// Ports:
//   clk, rst               - clock, synchronous active-high reset
//   flush                  - synchronous clear of all stage valid bits
//   in_valid/in_data/in_ready    - input handshake
//   out_valid/out_data/out_ready - output handshake (last stage)
//   count                  - registered number of valid stages, 0..DEPTH
module flop_pipe_sync_rst #(
  parameter int               WIDTH    = 8,
  parameter int               DEPTH    = 3,
  parameter logic [WIDTH-1:0] RST_VAL  = '0,
  parameter bit               RST_DATA = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] en;
  logic [DEPTH-1:0] up_v;
  logic [WIDTH-1:0] d    [DEPTH];
  logic [WIDTH-1:0] up_d [DEPTH];
  logic             in_hs;
  logic             out_hs;

  // Ready chain walked from the output back to the input: a stage may load
  // when it is empty or when everything downstream of it is moving.
  always_comb begin : p_ready_chain
    logic adv;
    adv = out_ready;
    en  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      en[i] = !v[i] || adv;
      adv   = en[i];
    end
  end

  assign in_ready  = en[0] && !flush;
  assign in_hs     = in_valid && in_ready;
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];
  assign out_hs    = out_valid && out_ready;

  // Stage 0 sees the accepted input beat; every other stage sees its predecessor.
  always_comb begin
    up_v    = '0;
    up_v[0] = in_hs;
    up_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      up_v[i] = v[i-1];
      up_d[i] = d[i-1];
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    flop_pipe_stage #(
      .WIDTH    (WIDTH),
      .RST_VAL  (RST_VAL),
      .RST_DATA (RST_DATA)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .en       (en[i]),
      .up_valid (up_v[i]),
      .up_data  (up_d[i]),
      .valid    (v[i]),
      .data     (d[i])
    );
  end

  // Tracked incrementally rather than as a popcount of v so it is a clean
  // flop output; a flush drops everything in flight, including any beat
  // that was about to enter.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      count <= count + CW'(in_hs) - CW'(out_hs);
    end
  end

endmodule

// File: tb/tb_flop_pipe_sync_rst.sv
module tb_flop_pipe_sync_rst;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [1:0]      iv, ir, ov, ordy, fl;
  logic [1:0][7:0] id, od;
  logic [1:0]      cnt_a;
  logic [0:0]      cnt_b;

  // Instance 0: DEPTH 3 with data reset to A5. Instance 1: DEPTH 1, no data reset.
  flop_pipe_sync_rst #(.WIDTH(8), .DEPTH(3), .RST_VAL(8'hA5), .RST_DATA(1'b1)) u_dut_a (
    .clk(clk), .rst(rst), .flush(fl[0]), .in_valid(iv[0]), .in_data(id[0]),
    .in_ready(ir[0]), .out_valid(ov[0]), .out_data(od[0]), .out_ready(ordy[0]),
    .count(cnt_a));

  flop_pipe_sync_rst #(.WIDTH(8), .DEPTH(1), .RST_VAL(8'h00), .RST_DATA(1'b0)) u_dut_b (
    .clk(clk), .rst(rst), .flush(fl[1]), .in_valid(iv[1]), .in_data(id[1]),
    .in_ready(ir[1]), .out_valid(ov[1]), .out_data(od[1]), .out_ready(ordy[1]),
    .count(cnt_b));

  // Reference model: each in-flight beat is a queue entry holding its stage
  // position. Every cycle the head leaves if it sits at the last stage and
  // the consumer is ready; every other beat moves forward by one unless the
  // beat ahead of it blocks.
  int         dep [2];
  int         pos_q [2][$];
  logic [7:0] dat_q [2][$];
  int         nxt   [2][$];
  logic [7:0] out_log [2][$];
  int         out_cyc [2][$];
  logic [7:0] acc_log [2][$];
  int         acc_cyc [2][$];
  bit         exp_ov [2];
  bit         exp_ir [2];
  bit         dlv    [2];
  logic       s_ir   [2];
  bit         mvalid;
  int         cyc;
  int         n_tests;
  int         n_fail;

  task automatic chk(input string tag, input int inst, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, inst, obs, exp);
    end
  endtask

  task automatic clear_logs(input int k);
    out_log[k].delete();
    out_cyc[k].delete();
    acc_log[k].delete();
    acc_cyc[k].delete();
  endtask

  // One clock cycle: predict, check the DUT mid-cycle, then advance the model.
  task automatic tick();
    int lim;
    int p;
    int first;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      exp_ov[k] = (pos_q[k].size() > 0) && (pos_q[k][0] == dep[k] - 1);
      dlv[k]    = exp_ov[k] && ordy[k];
      nxt[k].delete();
      lim   = dep[k] - 1;
      first = dlv[k] ? 1 : 0;
      for (int j = first; j < pos_q[k].size(); j++) begin
        p = pos_q[k][j] + 1;
        if (p > lim) p = lim;
        nxt[k].push_back(p);
        lim = p - 1;
      end
      exp_ir[k] = !fl[k] && ((nxt[k].size() == 0) || (nxt[k][nxt[k].size()-1] >= 1));
    end
    #3;
    s_ir[0] = ir[0];
    s_ir[1] = ir[1];
    if (mvalid) begin
      for (int k = 0; k < 2; k++) begin
        chk("in_ready", k, 32'(ir[k]), 32'(exp_ir[k]));
        chk("out_valid", k, 32'(ov[k]), 32'(exp_ov[k]));
        if (exp_ov[k]) chk("out_data", k, 32'(od[k]), 32'(dat_q[k][0]));
      end
      chk("count", 0, 32'(cnt_a), 32'(pos_q[0].size()));
      chk("count", 1, 32'(cnt_b), 32'(pos_q[1].size()));
      if (!fl[1]) chk("d1_ready_eq", 1, 32'(ir[1]), 32'(!ov[1] || ordy[1]));
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        pos_q[k].delete();
        dat_q[k].delete();
      end else begin
        if (dlv[k]) begin
          out_log[k].push_back(dat_q[k][0]);
          out_cyc[k].push_back(cyc);
          void'(dat_q[k].pop_front());
        end
        if (fl[k]) begin
          pos_q[k].delete();
          dat_q[k].delete();
        end else begin
          pos_q[k] = nxt[k];
          if (iv[k] && exp_ir[k]) begin
            pos_q[k].push_back(0);
            dat_q[k].push_back(id[k]);
            acc_log[k].push_back(id[k]);
            acc_cyc[k].push_back(cyc);
          end
        end
      end
    end
    if (rst) mvalid = 1'b1;
  endtask

  logic [7:0] fs_exp [4];
  logic [7:0] nb;
  int         nacc;

  initial begin
    dep[0] = 3; dep[1] = 1;
    n_tests = 0; n_fail = 0; cyc = 0; mvalid = 1'b0;
    rst = 1'b1; iv = '0; ordy = '0; fl = '0; id = '0;

    // Reset held for two cycles.
    tick();
    tick();
    chk("rst_out_valid", 0, 32'(ov[0]), 32'd0);
    chk("rst_count", 0, 32'(cnt_a), 32'd0);
    chk("rst_out_data", 0, 32'(od[0]), 32'hA5);
    chk("rst_count", 1, 32'(cnt_b), 32'd0);
    rst = 1'b0;
    ordy = 2'b11;
    #1;
    chk("rst_in_ready", 0, 32'(ir[0]), 32'd1);

    // Back-to-back streaming with the consumer always ready.
    clear_logs(0);
    for (int b = 1; b <= 16; b++) begin
      iv[0] = 1'b1;
      id[0] = 8'(b);
      tick();
      if (b >= 3) chk("stream_count", 0, 32'(cnt_a), 32'd3);
    end
    iv[0] = 1'b0;
    repeat (5) tick();
    chk("stream_n", 0, 32'(out_log[0].size()), 32'd16);
    if (out_log[0].size() == 16) begin
      for (int i = 0; i < 16; i++) chk("stream_order", 0, 32'(out_log[0][i]), 32'(i + 1));
      chk("stream_latency", 0, 32'(out_cyc[0][0] - acc_cyc[0][0]), 32'd3);
      chk("stream_rate", 0, 32'(out_cyc[0][15] - out_cyc[0][0]), 32'd15);
    end

    // Fill and stall.
    clear_logs(0);
    ordy[0] = 1'b0;
    iv[0] = 1'b1;
    id[0] = 8'h11; tick();
    id[0] = 8'h22; tick();
    id[0] = 8'h33; tick();
    id[0] = 8'h44; tick();
    chk("full_in_ready", 0, 32'(s_ir[0]), 32'd0);
    chk("full_count", 0, 32'(cnt_a), 32'd3);
    ordy[0] = 1'b1;
    for (int t = 0; t < 10 && acc_log[0].size() < 4; t++) tick();
    iv[0] = 1'b0;
    repeat (5) tick();
    fs_exp[0] = 8'h11; fs_exp[1] = 8'h22; fs_exp[2] = 8'h33; fs_exp[3] = 8'h44;
    chk("fill_n", 0, 32'(out_log[0].size()), 32'd4);
    if (out_log[0].size() == 4)
      for (int i = 0; i < 4; i++) chk("fill_order", 0, 32'(out_log[0][i]), 32'(fs_exp[i]));

    // Bubble collapse.
    clear_logs(0);
    ordy[0] = 1'b0;
    iv[0] = 1'b1; id[0] = 8'h55; tick();
    iv[0] = 1'b0; tick(); tick();
    iv[0] = 1'b1; id[0] = 8'h66; tick();
    iv[0] = 1'b0; tick();
    chk("bubble_count", 0, 32'(cnt_a), 32'd2);
    chk("bubble_head", 0, 32'(od[0]), 32'h55);
    ordy[0] = 1'b1;
    repeat (4) tick();
    chk("bubble_n", 0, 32'(out_log[0].size()), 32'd2);
    if (out_log[0].size() == 2) begin
      chk("bubble_first", 0, 32'(out_log[0][0]), 32'h55);
      chk("bubble_second", 0, 32'(out_log[0][1]), 32'h66);
      chk("bubble_adjacent", 0, 32'(out_cyc[0][1] - out_cyc[0][0]), 32'd1);
    end

    // Flush with three beats in flight and a beat offered in the flush cycle.
    ordy[0] = 1'b0;
    iv[0] = 1'b1;
    id[0] = 8'h71; tick();
    id[0] = 8'h72; tick();
    id[0] = 8'h73; tick();
    chk("preflush_count", 0, 32'(cnt_a), 32'd3);
    fl[0] = 1'b1; id[0] = 8'h74; tick();
    chk("flush_in_ready", 0, 32'(s_ir[0]), 32'd0);
    fl[0] = 1'b0; iv[0] = 1'b0;
    chk("flush_count", 0, 32'(cnt_a), 32'd0);
    chk("flush_out_valid", 0, 32'(ov[0]), 32'd0);
    chk("flush_data_kept", 0, 32'(od[0]), 32'h71);
    tick();
    clear_logs(0);
    ordy[0] = 1'b1;
    iv[0] = 1'b1; id[0] = 8'h75; tick();
    iv[0] = 1'b0;
    repeat (4) tick();
    chk("postflush_n", 0, 32'(out_log[0].size()), 32'd1);
    if (out_log[0].size() == 1) begin
      chk("postflush_data", 0, 32'(out_log[0][0]), 32'h75);
      chk("postflush_latency", 0, 32'(out_cyc[0][0] - acc_cyc[0][0]), 32'd3);
    end

    // Randomised traffic on both instances, including occasional flush and reset.
    for (int t = 0; t < 400; t++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int k = 0; k < 2; k++) begin
        iv[k]   = 1'($urandom_range(0, 1));
        ordy[k] = 1'($urandom_range(0, 1));
        fl[k]   = ($urandom_range(0, 19) == 0);
        id[k]   = 8'($urandom_range(0, 255));
      end
      tick();
    end
    rst = 1'b0; fl = '0; iv = '0; ordy = 2'b11;
    repeat (5) tick();
    chk("rand_drained", 0, 32'(cnt_a), 32'd0);
    chk("rand_drained", 1, 32'(cnt_b), 32'd0);

    // DEPTH=1: alternating out_ready under a continuous stream.
    clear_logs(1);
    ordy[0] = 1'b0;
    nb = 8'h80;
    for (int t = 0; t < 40; t++) begin
      nacc = acc_log[1].size();
      iv[1]   = 1'b1;
      id[1]   = nb;
      ordy[1] = ((t % 2) == 1);
      tick();
      if (acc_log[1].size() != nacc) nb = nb + 8'd1;
    end
    iv[1] = 1'b0; ordy[1] = 1'b1;
    repeat (3) tick();
    chk("d1_n", 1, 32'(out_log[1].size()), 32'd21);
    for (int i = 0; i < out_log[1].size(); i++)
      chk("d1_seq", 1, 32'(out_log[1][i]), 32'(8'h80 + 8'(i)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
